// File: rtl/register_file_pkg.sv
// ----------------------------------------------------------------------------
// register_file_pkg
// Shared sizing constants and types for the CPU register file and its read
// ports. NUM_REGS is derived from ADDR_W so every address value is a real
// register and no out-of-range decode can exist.
// ----------------------------------------------------------------------------
package register_file_pkg;

   localparam int DATA_W   = 18;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

   // Masked read used by every read port: a disabled port drives zero,
   // never the last value and never Z.
   function automatic reg_data_t masked_read(input logic      en,
                                             input reg_data_t word);
      return en ? word : '0;
   endfunction

endpackage : register_file_pkg

// File: rtl/regfile_read_port.sv
// ----------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of the register file: NUM_REGS:1 mux selected
// by the address, gated to zero when the port is disabled. Zero latency.
//
// Ports
//   rd_en_i    in   1          port enable
//   rd_addr_i  in   ADDR_W     register address
//   regs_i     in   NUM_REGS x DATA_W   current register contents
//   rd_data_o  out  DATA_W     selected register, or 0 when disabled
// ----------------------------------------------------------------------------
module regfile_read_port
   import register_file_pkg::*;
(
   input  logic      rd_en_i,
   input  reg_addr_t rd_addr_i,
   input  reg_data_t regs_i [NUM_REGS],
   output reg_data_t rd_data_o
);

   reg_data_t sel_word;

   always_comb begin
      sel_word  = regs_i[rd_addr_i];
      rd_data_o = masked_read(rd_en_i, sel_word);
   end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
// General-purpose CPU register file: 16 x 18-bit registers, one synchronous
// write port and two independently enabled combinational read ports.
// R0 is ordinary storage (not hardwired to zero). Reads show the stored
// value only; a write becomes visible after its clock edge (no bypass).
// Reset is asynchronous and clears every register, overriding a
// coincident write.
//
// Ports
//   Clk            in   1        system clock, rising edge
//   Rst_n          in   1        asynchronous active-low reset
//   ReadEnable1    in   1        read port 1 enable
//   ReadRegister1  in   ADDR_W   read port 1 address
//   ReadData1      out  DATA_W   read port 1 data (0 when disabled)
//   ReadEnable2    in   1        read port 2 enable
//   ReadRegister2  in   ADDR_W   read port 2 address
//   ReadData2      out  DATA_W   read port 2 data (0 when disabled)
//   WriteRegister  in   ADDR_W   write address
//   WriteData      in   DATA_W   write data
//   RegWrite       in   1        write enable
// ----------------------------------------------------------------------------
module register_file
   import register_file_pkg::*;
(
   input  logic      Clk,
   input  logic      Rst_n,
   input  logic      ReadEnable1,
   input  reg_addr_t ReadRegister1,
   output reg_data_t ReadData1,
   input  logic      ReadEnable2,
   input  reg_addr_t ReadRegister2,
   output reg_data_t ReadData2,
   input  reg_addr_t WriteRegister,
   input  reg_data_t WriteData,
   input  logic      RegWrite
);

   reg_data_t regs_q [NUM_REGS];
   reg_data_t regs_d [NUM_REGS];

   always_comb begin
      regs_d = regs_q;
      if (RegWrite) begin
         regs_d[WriteRegister] = WriteData;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Both ports read the registered array directly, so a same-address
   // write is seen only after the edge that commits it.
   regfile_read_port u_read_port1 (
      .rd_en_i   (ReadEnable1),
      .rd_addr_i (ReadRegister1),
      .regs_i    (regs_q),
      .rd_data_o (ReadData1)
   );

   regfile_read_port u_read_port2 (
      .rd_en_i   (ReadEnable2),
      .rd_addr_i (ReadRegister2),
      .regs_i    (regs_q),
      .rd_data_o (ReadData2)
   );

endmodule : register_file

// File: tb/tb_register_file.sv
`timescale 1ns/1ps
module tb_register_file;
   import register_file_pkg::*;

   logic      Clk;
   logic      Rst_n;
   logic      ReadEnable1;
   reg_addr_t ReadRegister1;
   reg_data_t ReadData1;
   logic      ReadEnable2;
   reg_addr_t ReadRegister2;
   reg_data_t ReadData2;
   reg_addr_t WriteRegister;
   reg_data_t WriteData;
   logic      RegWrite;

   register_file dut (
      .Clk           (Clk),
      .Rst_n         (Rst_n),
      .ReadEnable1   (ReadEnable1),
      .ReadRegister1 (ReadRegister1),
      .ReadData1     (ReadData1),
      .ReadEnable2   (ReadEnable2),
      .ReadRegister2 (ReadRegister2),
      .ReadData2     (ReadData2),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .RegWrite      (RegWrite)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      string     tag;
      bit        port2;
      reg_data_t exp;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int        tests_run = 0;
   int        tests_failed = 0;
   reg_data_t model [NUM_REGS];

   task automatic check_eq(input string tag, input reg_data_t obs, input reg_data_t exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input string tag, input bit port2, input reg_data_t exp);
      sb_entry_t e;
      e.tag   = tag;
      e.port2 = port2;
      e.exp   = exp;
      sb_q.push_back(e);
   endtask

   // Pops every pending expectation and compares against the live port.
   task automatic drain();
      sb_entry_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_eq(e.tag, e.port2 ? ReadData2 : ReadData1, e.exp);
      end
   endtask

   function automatic reg_data_t model_rd(input logic en, input reg_addr_t a);
      return en ? model[a] : '0;
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic write_reg(input reg_addr_t a, input reg_data_t d);
      RegWrite      = 1'b1;
      WriteRegister = a;
      WriteData     = d;
      tick();
      RegWrite      = 1'b0;
      model[a]      = d;
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
   endtask

   logic [15:0] addr_wide;

   initial begin
      Rst_n = 1'b1;
      ReadEnable1 = 1'b1; ReadRegister1 = '0;
      ReadEnable2 = 1'b1; ReadRegister2 = 4'd15;
      WriteRegister = '0; WriteData = '0; RegWrite = 1'b0;
      model_clear();
      #1 Rst_n = 1'b0;
      #1;
      push_exp("init_rst_p1", 1'b0, 18'h0);
      push_exp("init_rst_p2", 1'b1, 18'h0);
      drain();
      tick();
      Rst_n = 1'b1;
      tick();

      // write then read R5, old value before the edge
      RegWrite = 1'b1; WriteRegister = 4'd5; WriteData = 18'd123;
      ReadEnable2 = 1'b1; ReadRegister2 = 4'd5;
      #1;
      push_exp("wr5_before_edge", 1'b1, 18'd0);
      drain();
      tick();
      RegWrite = 1'b0; model[5] = 18'd123;
      push_exp("wr5_after_edge", 1'b1, 18'd123);
      drain();

      // enable gating with no clock edge in between
      ReadEnable1 = 1'b0; ReadRegister1 = 4'd5;
      #1;
      push_exp("en1_off", 1'b0, 18'd0);
      drain();
      ReadEnable1 = 1'b1;
      #1;
      push_exp("en1_on", 1'b0, 18'd123);
      drain();
      ReadEnable2 = 1'b0;
      #1;
      push_exp("en2_off", 1'b1, 18'd0);
      drain();
      ReadEnable2 = 1'b1;

      // write gating, then truncated address
      RegWrite = 1'b0; WriteRegister = 4'd9; WriteData = 18'h3FFFF;
      repeat (3) tick();
      ReadRegister1 = 4'd9;
      #1;
      push_exp("r9_gated", 1'b0, 18'd0);
      drain();
      write_reg(4'd9, 18'h3FFFF);
      ReadRegister1 = 4'd0;
      addr_wide = 16'd1001;
      ReadRegister1 = addr_wide[ADDR_W-1:0];
      #1;
      push_exp("r9_trunc_addr", 1'b0, 18'h3FFFF);
      drain();

      // dual read and R0 writable
      write_reg(4'd0, 18'h2AAAA);
      write_reg(4'd15, 18'h15555);
      ReadRegister1 = 4'd0; ReadRegister2 = 4'd15;
      #1;
      push_exp("r0_p1", 1'b0, 18'h2AAAA);
      push_exp("r15_p2", 1'b1, 18'h15555);
      drain();
      ReadRegister1 = 4'd15;
      #1;
      push_exp("both15_p1", 1'b0, 18'h15555);
      push_exp("both15_p2", 1'b1, 18'h15555);
      drain();

      // read during write to the same address
      write_reg(4'd3, 18'd7);
      ReadRegister1 = 4'd3;
      RegWrite = 1'b1; WriteRegister = 4'd3; WriteData = 18'd42;
      #1;
      push_exp("rdw_old", 1'b0, 18'd7);
      drain();
      tick();
      RegWrite = 1'b0; model[3] = 18'd42;
      push_exp("rdw_new", 1'b0, 18'd42);
      drain();

      // randomized traffic against the model
      for (int it = 0; it < 40; it++) begin
         RegWrite      = ($urandom_range(0, 1) == 1);
         WriteRegister = reg_addr_t'($urandom_range(0, NUM_REGS-1));
         WriteData     = reg_data_t'($urandom());
         ReadEnable1   = ($urandom_range(0, 3) != 0);
         ReadEnable2   = ($urandom_range(0, 3) != 0);
         ReadRegister1 = reg_addr_t'($urandom_range(0, NUM_REGS-1));
         ReadRegister2 = (it % 4 == 0) ? WriteRegister
                                       : reg_addr_t'($urandom_range(0, NUM_REGS-1));
         #1;
         push_exp("rnd_pre_p1", 1'b0, model_rd(ReadEnable1, ReadRegister1));
         push_exp("rnd_pre_p2", 1'b1, model_rd(ReadEnable2, ReadRegister2));
         drain();
         tick();
         if (RegWrite) model[WriteRegister] = WriteData;
         push_exp("rnd_post_p1", 1'b0, model_rd(ReadEnable1, ReadRegister1));
         push_exp("rnd_post_p2", 1'b1, model_rd(ReadEnable2, ReadRegister2));
         drain();
      end
      RegWrite = 1'b0;

      // make sure plenty of registers are nonzero before the reset test
      for (int i = 0; i < NUM_REGS; i++) write_reg(reg_addr_t'(i), reg_data_t'(18'h100 + i));

      // asynchronous reset mid-cycle, checked before the next clock edge
      ReadEnable1 = 1'b1; ReadEnable2 = 1'b1;
      @(posedge Clk);
      #2 Rst_n = 1'b0;
      model_clear();
      for (int a = 0; a < NUM_REGS; a++) begin
         ReadRegister1 = reg_addr_t'(a);
         ReadRegister2 = reg_addr_t'(NUM_REGS-1-a);
         #0.2;
         push_exp("async_rst_p1", 1'b0, 18'h0);
         push_exp("async_rst_p2", 1'b1, 18'h0);
         drain();
      end

      // reset overrides a coincident write
      RegWrite = 1'b1; WriteRegister = 4'd7; WriteData = 18'h1234;
      tick();
      RegWrite = 1'b0;
      Rst_n = 1'b1;
      ReadRegister1 = 4'd7;
      #1;
      push_exp("rst_over_write", 1'b0, 18'h0);
      drain();
      tick();
      push_exp("rst_over_write_hold", 1'b0, 18'h0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_register_file
